// File: rtl/iir_pkg.sv
// Shared definitions for the IIR second-order-section sequencer.
//   sos_state_e      : sequencer FSM states
//   A0 / A1 / B      : coefficient slot addresses inside one section
//   SAMP_W_DEF       : default sample width   (3 integer + 22 fraction bits)
//   COEFF_W_DEF      : default coefficient width (2 integer + 15 fraction bits)
package iir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC0 = 2'd1,
    MAC1 = 2'd2,
    DONE = 2'd3
  } sos_state_e;

  localparam logic [1:0] A0 = 2'd0;
  localparam logic [1:0] A1 = 2'd1;
  localparam logic [1:0] B  = 2'd2;

  localparam int SAMP_W_DEF  = 25;
  localparam int COEFF_W_DEF = 17;

endpackage

// File: rtl/iir_sos_seq.sv
// Sequencer for a cascade of N_SEC second-order IIR sections.
// Accepts one sample at a time, steps the sections through two multiply
// phases (MAC0 / MAC1), captures the cascade output, and owns the
// coefficient write port into the sections.
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   samp_valid/samp_in/samp_ready : input sample handshake
//   cfg_valid/cfg_sec/cfg_addr/
//   cfg_data/cfg_ready            : coefficient write handshake
//   cfg_err                       : sticky, set by a rejected write
//   ce, mult_sel, sec_nrst        : section control (registered)
//   c_we, c_addr, c_in            : coefficient write into one section
//   din                           : sample fed to the first section
//   sec_dout                      : output of the last section
//   out_valid/out_data            : filtered result, one-cycle pulse
//   overrun, ovr_cnt              : dropped-sample tracking
//
// Build option: define IIR_SOS_SEQ_OVERRUN_EN to enable overrun tracking;
// otherwise overrun and ovr_cnt are tied to 0.
module iir_sos_seq
  import iir_pkg::*;
#(
  parameter int N_SEC   = 4,
  parameter int SAMP_W  = SAMP_W_DEF,
  parameter int COEFF_W = COEFF_W_DEF,
  localparam int SEC_W  = (N_SEC > 1) ? $clog2(N_SEC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               samp_valid,
  input  logic [SAMP_W-1:0]  samp_in,
  output logic               samp_ready,
  input  logic               cfg_valid,
  input  logic [SEC_W-1:0]   cfg_sec,
  input  logic [1:0]         cfg_addr,
  input  logic [COEFF_W-1:0] cfg_data,
  output logic               cfg_ready,
  output logic               cfg_err,
  output logic               ce,
  output logic               mult_sel,
  output logic               sec_nrst,
  output logic [N_SEC-1:0]   c_we,
  output logic [1:0]         c_addr,
  output logic [COEFF_W-1:0] c_in,
  output logic [SAMP_W-1:0]  din,
  input  logic [SAMP_W-1:0]  sec_dout,
  output logic               out_valid,
  output logic [SAMP_W-1:0]  out_data,
  output logic               overrun,
  output logic [7:0]         ovr_cnt
);

  sos_state_e         state_q, state_d;
  logic               ce_q, ce_d;
  logic               mult_sel_q, mult_sel_d;
  logic               sec_nrst_q;
  logic [N_SEC-1:0]   c_we_q, c_we_d;
  logic [1:0]         c_addr_q, c_addr_d;
  logic [COEFF_W-1:0] c_in_q, c_in_d;
  logic [SAMP_W-1:0]  din_q, din_d;
  logic               out_valid_q, out_valid_d;
  logic [SAMP_W-1:0]  out_data_q, out_data_d;
  logic               cfg_err_q, cfg_err_d;

  logic samp_fire, cfg_fire, cfg_ok;

  always_comb begin
    state_d     = state_q;
    din_d       = din_q;
    out_data_d  = out_data_q;
    c_addr_d    = c_addr_q;
    c_in_d      = c_in_q;
    cfg_err_d   = cfg_err_q;
    c_we_d      = '0;

    samp_ready = (state_q == IDLE) || (state_q == DONE);
    // A pending sample always wins over a config write in IDLE.
    cfg_ready  = (state_q == IDLE) && !samp_valid;
    samp_fire  = samp_valid && samp_ready;
    cfg_fire   = cfg_valid && cfg_ready;
    cfg_ok     = (cfg_addr <= B) && (int'(cfg_sec) < N_SEC);

    unique case (state_q)
      IDLE: if (samp_fire) state_d = MAC0;
      MAC0: state_d = MAC1;
      MAC1: state_d = DONE;
      DONE: state_d = samp_fire ? MAC0 : IDLE;
      default: state_d = IDLE;
    endcase

    if (samp_fire) din_d = samp_in;

    // Registered controls decoded from the state being entered so they
    // line up with the state register.
    ce_d       = (state_d == MAC0) || (state_d == MAC1);
    mult_sel_d = (state_d == MAC1);

    out_valid_d = (state_q == DONE);
    if (state_q == DONE) out_data_d = sec_dout;

    // Writes only happen from IDLE with no sample, so c_we never
    // overlaps ce.
    for (int i = 0; i < N_SEC; i++)
      c_we_d[i] = cfg_fire && cfg_ok && (int'(cfg_sec) == i);
    if (cfg_fire && cfg_ok) begin
      c_addr_d = cfg_addr;
      c_in_d   = cfg_data;
    end
    if (cfg_fire && !cfg_ok) cfg_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ce_q        <= 1'b0;
      mult_sel_q  <= 1'b0;
      sec_nrst_q  <= 1'b0;
      c_we_q      <= '0;
      c_addr_q    <= '0;
      c_in_q      <= '0;
      din_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ce_q        <= ce_d;
      mult_sel_q  <= mult_sel_d;
      sec_nrst_q  <= 1'b1;
      c_we_q      <= c_we_d;
      c_addr_q    <= c_addr_d;
      c_in_q      <= c_in_d;
      din_q       <= din_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign ce        = ce_q;
  assign mult_sel  = mult_sel_q;
  assign sec_nrst  = sec_nrst_q;
  assign c_we      = c_we_q;
  assign c_addr    = c_addr_q;
  assign c_in      = c_in_q;
  assign din       = din_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cfg_err   = cfg_err_q;

`ifdef IIR_SOS_SEQ_OVERRUN_EN
  logic       overrun_q, overrun_d;
  logic [7:0] ovr_cnt_q, ovr_cnt_d;
  logic       drop;

  always_comb begin
    drop      = samp_valid && !samp_ready;
    overrun_d = overrun_q | drop;
    ovr_cnt_d = ovr_cnt_q;
    if (drop && (ovr_cnt_q != 8'hFF)) ovr_cnt_d = ovr_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      overrun_q <= overrun_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign overrun = overrun_q;
  assign ovr_cnt = ovr_cnt_q;
`else
  assign overrun = 1'b0;
  assign ovr_cnt = '0;
`endif

endmodule
